// File: rtl/soundgen_pkg.sv
// ---------------------------------------------------------------------------
// soundgen_pkg
//
// Purpose:
//    Definitions shared by the PWM generator and the PWM demodulator of the
//    sound path: the default measurement frame length, the rule that derives
//    the signed sample width from a frame length, and the sample type used at
//    the default frame length.
//
// Contents:
//    FRAME_LEN_DEFAULT    default frame length in clock cycles (power of two)
//    SYNC_STAGES_DEFAULT  default depth of the input synchronizers
//    sampleWidth()        signed sample width for a given frame length
//    SAMPLE_W             sample width at the default frame length
//    sample_t             signed sample type at the default frame length
// ---------------------------------------------------------------------------
package soundgen_pkg;

   localparam int FRAME_LEN_DEFAULT   = 256;
   localparam int SYNC_STAGES_DEFAULT = 2;

   // A frame of length N can produce any difference from -N to +N. Holding
   // +N needs log2(N)+1 magnitude bits, plus one sign bit.
   function automatic int sampleWidth(input int frameLen);
      return $clog2(frameLen) + 2;
   endfunction

   localparam int SAMPLE_W = sampleWidth(FRAME_LEN_DEFAULT);

   typedef logic signed [SAMPLE_W-1:0] sample_t;

endpackage

// File: rtl/pwm_sync.sv
// ---------------------------------------------------------------------------
// pwm_sync
//
// Purpose:
//    Multi-flop synchronizer that brings a single PWM stream, which is
//    asynchronous to clk, into the clk domain. The output lags the input by
//    STAGES rising edges.
//
// Ports:
//    clk    in   sole clock, rising edge
//    reset  in   synchronous, active-high; clears every stage
//    d_i    in   asynchronous input bit
//    q_o    out  synchronized bit (last stage)
// ---------------------------------------------------------------------------
module pwm_sync
   import soundgen_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;
   logic [STAGES-1:0] sync_d;

   // The new input enters at bit 0 and moves up one stage per edge, so the
   // top bit has had STAGES-1 extra flop times to settle any metastability.
   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_i};
   end

   // Shift register with synchronous clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pwm_demod.sv
// ---------------------------------------------------------------------------
// pwm_demod
//
// Purpose:
//    Recovers a signed sample from a pair of PWM streams, one for the
//    positive half and one for the negative half. Over each frame of
//    FRAME_LEN cycles it counts the cycles with only pwm_pos high and the
//    cycles with only pwm_neg high. At the end of the frame it delivers the
//    difference as a two's complement sample through a valid/ready holding
//    register. Cycles with both inputs high are not counted and mark the
//    frame as conflicted.
//
// Ports:
//    clk              in   sole clock, rising edge
//    reset            in   synchronous, active-high
//    en               in   demodulation enable; low discards the partial frame
//    pwm_pos          in   positive-half PWM stream (asynchronous)
//    pwm_neg          in   negative-half PWM stream (asynchronous)
//    sample           out  SW-bit signed recovered sample
//    sample_conflict  out  delivered frame had a cycle with both inputs high
//    sample_valid     out  holding register is full
//    sample_ready     in   consumer accepts the sample this edge
//    overrun          out  sticky: a finished frame overwrote an unaccepted sample
//    clr_overrun      in   clears overrun (a simultaneous set wins)
// ---------------------------------------------------------------------------
module pwm_demod
   import soundgen_pkg::*;
#(
   parameter  int FRAME_LEN   = FRAME_LEN_DEFAULT,
   parameter  int SYNC_STAGES = SYNC_STAGES_DEFAULT,
   localparam int SW          = sampleWidth(FRAME_LEN)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic                 pwm_pos,
   input  logic                 pwm_neg,
   output logic signed [SW-1:0] sample,
   output logic                 sample_conflict,
   output logic                 sample_valid,
   input  logic                 sample_ready,
   output logic                 overrun,
   input  logic                 clr_overrun
);

   // FW bits address a frame cycle. CW bits hold a per-frame count, which
   // can reach FRAME_LEN itself when every cycle of the frame counts.
   localparam int FW = $clog2(FRAME_LEN);
   localparam int CW = FW + 1;
   localparam logic [FW-1:0] FCNT_LAST = FW'(FRAME_LEN - 1);

   logic posBit;
   logic negBit;

   logic [FW-1:0] frameCnt_q, frameCnt_d;
   logic [CW-1:0] posCnt_q, posCnt_d;
   logic [CW-1:0] negCnt_q, negCnt_d;
   logic          conflictAcc_q, conflictAcc_d;

   logic signed [SW-1:0] sample_q, sample_d;
   logic                 sampleConflict_q, sampleConflict_d;
   logic                 sampleValid_q, sampleValid_d;
   logic                 overrun_q, overrun_d;

   logic          posInc;
   logic          negInc;
   logic          bothHigh;
   logic [CW-1:0] posFinal;
   logic [CW-1:0] negFinal;
   logic          conflictFinal;
   logic          frameEnd;
   logic          transfer;
   logic          overrunSet;
   logic signed [SW-1:0] result;

   // One synchronizer per stream. The counters only ever see the
   // synchronized bits.
   pwm_sync #(
      .STAGES (SYNC_STAGES)
   ) uPosSync (
      .clk   (clk),
      .reset (reset),
      .d_i   (pwm_pos),
      .q_o   (posBit)
   );

   pwm_sync #(
      .STAGES (SYNC_STAGES)
   ) uNegSync (
      .clk   (clk),
      .reset (reset),
      .d_i   (pwm_neg),
      .q_o   (negBit)
   );

   // This cycle's contribution to the frame. The "final" values include
   // this cycle, so on the frame-end cycle they are the complete frame
   // totals. The result is formed from them rather than from the registered
   // counts.
   always_comb begin
      posInc        = posBit & ~negBit;
      negInc        = negBit & ~posBit;
      bothHigh      = posBit & negBit;
      posFinal      = posCnt_q + CW'(posInc);
      negFinal      = negCnt_q + CW'(negInc);
      conflictFinal = conflictAcc_q | bothHigh;
      frameEnd      = en && (frameCnt_q == FCNT_LAST);
      // Both totals are at most FRAME_LEN, so after zero-extension to SW
      // bits the difference cannot overflow.
      result        = $signed({1'b0, posFinal}) - $signed({1'b0, negFinal});
   end

   // Frame bookkeeping. While en is low everything is held at zero, so the
   // first enabled cycle is always frame cycle 0. On the frame-end cycle
   // everything restarts from zero in the same edge that loads the result.
   always_comb begin
      frameCnt_d    = '0;
      posCnt_d      = '0;
      negCnt_d      = '0;
      conflictAcc_d = 1'b0;
      if (en && !frameEnd) begin
         frameCnt_d    = frameCnt_q + FW'(1);
         posCnt_d      = posFinal;
         negCnt_d      = negFinal;
         conflictAcc_d = conflictFinal;
      end
   end

   // Output holding register and handshake. A new result always loads. If
   // the consumer takes the old sample on the same edge, nothing is lost and
   // valid simply stays high. If the held sample was not accepted, it is
   // overwritten and overrun is flagged. A set of overrun takes priority
   // over a clear on the same edge.
   always_comb begin
      sample_d         = sample_q;
      sampleConflict_d = sampleConflict_q;
      sampleValid_d    = sampleValid_q;
      overrun_d        = overrun_q;

      transfer   = sampleValid_q & sample_ready;
      overrunSet = frameEnd & sampleValid_q & ~sample_ready;

      if (frameEnd) begin
         sample_d         = result;
         sampleConflict_d = conflictFinal;
         sampleValid_d    = 1'b1;
      end else if (transfer) begin
         sampleValid_d    = 1'b0;
      end

      if (overrunSet) begin
         overrun_d = 1'b1;
      end else if (clr_overrun) begin
         overrun_d = 1'b0;
      end
   end

   // State registers with synchronous reset. Reset discards both the
   // partial frame and any held sample.
   always_ff @(posedge clk) begin
      if (reset) begin
         frameCnt_q       <= '0;
         posCnt_q         <= '0;
         negCnt_q         <= '0;
         conflictAcc_q    <= 1'b0;
         sample_q         <= '0;
         sampleConflict_q <= 1'b0;
         sampleValid_q    <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         frameCnt_q       <= frameCnt_d;
         posCnt_q         <= posCnt_d;
         negCnt_q         <= negCnt_d;
         conflictAcc_q    <= conflictAcc_d;
         sample_q         <= sample_d;
         sampleConflict_q <= sampleConflict_d;
         sampleValid_q    <= sampleValid_d;
         overrun_q        <= overrun_d;
      end
   end

   assign sample          = sample_q;
   assign sample_conflict = sampleConflict_q;
   assign sample_valid    = sampleValid_q;
   assign overrun         = overrun_q;

endmodule
